// File: rtl/rvj1_timer_pkg.sv
// ============================================================================
// Module   : rvj1_timer_pkg
// Purpose  : Shared register map, bit indices and write-strobe bundle for the
//            rvj1 multi-channel timer (rvj1_timer_multi / rvj1_timer_chan).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package rvj1_timer_pkg;

    localparam int         c_ch_stride      = 32'h20;
    localparam int         c_ch_stride_lsb  = $clog2(c_ch_stride);

    localparam logic [4:0] c_off_ctrl       = 5'h00;
    localparam logic [4:0] c_off_cmp        = 5'h04;
    localparam logic [4:0] c_off_count      = 5'h08;
    localparam logic [4:0] c_off_status     = 5'h0C;
    localparam logic [4:0] c_off_capt       = 5'h10;

    localparam int         c_ctrl_en        = 0;
    localparam int         c_ctrl_oneshot   = 1;
    localparam int         c_ctrl_irq_en    = 2;
    localparam int         c_ctrl_presc_lsb = 8;

    localparam int         c_stat_pend      = 0;
    localparam int         c_stat_capt_pend = 1;

    typedef struct packed {
        logic ctrl;
        logic cmp;
        logic count;
        logic status;
    } chan_we_t;

endpackage

`default_nettype wire

// File: rtl/rvj1_timer_chan.sv
// ============================================================================
// Module   : rvj1_timer_chan
// Purpose  : One timer channel: prescaler, up-counter, compare, one-shot mode,
//            sticky flags and level interrupt. Capture logic under
//            TIMER_CAPTURE_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rvj1_timer_chan
    import rvj1_timer_pkg::*;
#(
    parameter int CNT_W   = 32,
    parameter int PRESC_W = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  chan_we_t    i_we,
    input  logic [31:0] i_wdata,
    input  logic        i_capture,
    output logic [31:0] o_ctrl,
    output logic [31:0] o_cmp,
    output logic [31:0] o_count,
    output logic [31:0] o_status,
    output logic [31:0] o_capt,
    output logic        o_irq
);

    logic               r_en;
    logic               r_oneshot;
    logic               r_irq_en;
    logic               r_pend;
    logic [PRESC_W-1:0] r_presc;
    logic [PRESC_W-1:0] r_div;
    logic [CNT_W-1:0]   r_cmp;
    logic [CNT_W-1:0]   r_count;
    logic               w_tick;
    logic               w_match;
    logic               w_capt_pend;
    logic [CNT_W-1:0]   w_capt;
    logic               w_unused_wdata;

    assign w_tick         = r_en && (r_div == r_presc);
    assign w_match        = w_tick && (r_count == r_cmp);
    assign w_unused_wdata = ^i_wdata;

    // Priorities: CTRL write over one-shot clear, COUNT write over tick,
    // hardware PEND set over software W1C.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_en      <= 1'b0;
            r_oneshot <= 1'b0;
            r_irq_en  <= 1'b0;
            r_presc   <= '0;
            r_div     <= '0;
            r_cmp     <= '0;
            r_count   <= '0;
            r_pend    <= 1'b0;
        end else begin
            if (i_we.ctrl) begin
                r_en      <= i_wdata[c_ctrl_en];
                r_oneshot <= i_wdata[c_ctrl_oneshot];
                r_irq_en  <= i_wdata[c_ctrl_irq_en];
                r_presc   <= i_wdata[c_ctrl_presc_lsb +: PRESC_W];
            end else if (w_match && r_oneshot) begin
                r_en <= 1'b0;
            end

            if (i_we.ctrl || !r_en || w_tick) r_div <= '0;
            else                              r_div <= r_div + PRESC_W'(1);

            if (i_we.cmp) r_cmp <= i_wdata[CNT_W-1:0];

            if (i_we.count)   r_count <= i_wdata[CNT_W-1:0];
            else if (w_match) r_count <= '0;
            else if (w_tick)  r_count <= r_count + CNT_W'(1);

            if (w_match)                                  r_pend <= 1'b1;
            else if (i_we.status && i_wdata[c_stat_pend]) r_pend <= 1'b0;
        end
    end

`ifdef TIMER_CAPTURE_EN
    logic [1:0]       r_capt_sync;
    logic             r_capt_prev;
    logic             r_capt_pend;
    logic [CNT_W-1:0] r_capt;
    logic             w_capt_rise;

    assign w_capt_rise = r_capt_sync[1] && !r_capt_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_capt_sync <= '0;
            r_capt_prev <= 1'b0;
            r_capt_pend <= 1'b0;
            r_capt      <= '0;
        end else begin
            r_capt_sync <= {r_capt_sync[0], i_capture};
            r_capt_prev <= r_capt_sync[1];
            // r_count here is the pre-write value, so a coinciding COUNT write is not seen
            if (w_capt_rise) r_capt <= r_count;
            if (w_capt_rise)                                       r_capt_pend <= 1'b1;
            else if (i_we.status && i_wdata[c_stat_capt_pend]) r_capt_pend <= 1'b0;
        end
    end

    assign w_capt_pend = r_capt_pend;
    assign w_capt      = r_capt;
`else
    logic w_unused_capture;

    assign w_unused_capture = i_capture;
    assign w_capt_pend      = 1'b0;
    assign w_capt           = '0;
`endif

    assign o_irq = r_irq_en && (r_pend || w_capt_pend);

    always_comb begin
        o_ctrl                                = '0;
        o_ctrl[c_ctrl_en]                     = r_en;
        o_ctrl[c_ctrl_oneshot]                = r_oneshot;
        o_ctrl[c_ctrl_irq_en]                 = r_irq_en;
        o_ctrl[c_ctrl_presc_lsb +: PRESC_W]   = r_presc;
        o_cmp                                 = '0;
        o_cmp[CNT_W-1:0]                      = r_cmp;
        o_count                               = '0;
        o_count[CNT_W-1:0]                    = r_count;
        o_status                              = '0;
        o_status[c_stat_pend]                 = r_pend;
        o_status[c_stat_capt_pend]            = w_capt_pend;
        o_capt                                = '0;
        o_capt[CNT_W-1:0]                     = w_capt;
    end

endmodule

`default_nettype wire

// File: rtl/rvj1_timer_multi.sv
// ============================================================================
// Module   : rvj1_timer_multi
// Purpose  : NUM_CH-channel timer/compare peripheral on the rvj1 req/we bus.
//            Optional input capture enabled by defining TIMER_CAPTURE_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rvj1_timer_multi
    import rvj1_timer_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int CNT_W   = 32,
    parameter int PRESC_W = 8,
    parameter int ADDR_W  = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    output logic [31:0]       rdata_o,
    output logic              rvalid_o,
    input  logic [NUM_CH-1:0] capture_i,
    output logic [NUM_CH-1:0] irq_o
);

    localparam int c_ch_idx_w = ADDR_W - c_ch_stride_lsb;

    logic [c_ch_idx_w-1:0] w_ch_idx;
    logic [4:0]            w_off;
    logic                  w_wr;
    logic [31:0]           w_rdata;
    logic                  w_unused_addr;
    logic [31:0]           w_ctrl_rd   [NUM_CH];
    logic [31:0]           w_cmp_rd    [NUM_CH];
    logic [31:0]           w_count_rd  [NUM_CH];
    logic [31:0]           w_status_rd [NUM_CH];
    logic [31:0]           w_capt_rd   [NUM_CH];
    logic [31:0]           r_rdata;
    logic                  r_rvalid;

    assign w_ch_idx      = addr_i[ADDR_W-1:c_ch_stride_lsb];
    assign w_off         = {addr_i[c_ch_stride_lsb-1:2], 2'b00};
    assign w_wr          = req_i && we_i;
    assign w_unused_addr = ^addr_i[1:0];

    for (genvar n = 0; n < NUM_CH; n++) begin : g_chan
        logic     w_hit;
        chan_we_t w_we;

        assign w_hit       = w_wr && (w_ch_idx == c_ch_idx_w'(n));
        assign w_we.ctrl   = w_hit && (w_off == c_off_ctrl);
        assign w_we.cmp    = w_hit && (w_off == c_off_cmp);
        assign w_we.count  = w_hit && (w_off == c_off_count);
        assign w_we.status = w_hit && (w_off == c_off_status);

        rvj1_timer_chan #(
            .CNT_W   (CNT_W),
            .PRESC_W (PRESC_W)
        ) u_chan (
            .clk       (clk_i),
            .rst       (rst_i),
            .i_we      (w_we),
            .i_wdata   (wdata_i),
            .i_capture (capture_i[n]),
            .o_ctrl    (w_ctrl_rd[n]),
            .o_cmp     (w_cmp_rd[n]),
            .o_count   (w_count_rd[n]),
            .o_status  (w_status_rd[n]),
            .o_capt    (w_capt_rd[n]),
            .o_irq     (irq_o[n])
        );
    end

    // Channel indices at or above NUM_CH match nothing and read as zero.
    always_comb begin
        w_rdata = '0;
        for (int n = 0; n < NUM_CH; n++) begin
            if (w_ch_idx == c_ch_idx_w'(n)) begin
                case (w_off)
                    c_off_ctrl:   w_rdata = w_ctrl_rd[n];
                    c_off_cmp:    w_rdata = w_cmp_rd[n];
                    c_off_count:  w_rdata = w_count_rd[n];
                    c_off_status: w_rdata = w_status_rd[n];
                    c_off_capt:   w_rdata = w_capt_rd[n];
                    default:      w_rdata = '0;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
        end else begin
            r_rvalid <= req_i;
            r_rdata  <= (req_i && !we_i) ? w_rdata : '0;
        end
    end

    assign rdata_o  = r_rdata;
    assign rvalid_o = r_rvalid;

endmodule

`default_nettype wire

// File: tb/tb_rvj1_timer_multi.sv
// ============================================================================
// Module   : tb_rvj1_timer_multi
// Purpose  : Directed self-checking bench for rvj1_timer_multi (CNT_W=8);
//            read data is checked through an expected-value queue.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rvj1_timer_multi;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        req_i = 1'b0;
    logic        we_i = 1'b0;
    logic [7:0]  addr_i = '0;
    logic [31:0] wdata_i = '0;
    logic [31:0] rdata_o;
    logic        rvalid_o;
    logic [3:0]  capture_i = '0;
    logic [3:0]  irq_o;

    int checks = 0;
    int failures = 0;
    bit mon_en = 1'b0;
    bit req_prev;
    bit we_prev;

    typedef struct packed {
        logic [7:0]  addr;
        logic [31:0] exp;
    } sb_t;

    sb_t sb_q[$];
    sb_t item;

`ifdef TIMER_CAPTURE_EN
    localparam bit c_capt = 1'b1;
`else
    localparam bit c_capt = 1'b0;
`endif

    rvj1_timer_multi #(
        .NUM_CH  (4),
        .CNT_W   (8),
        .PRESC_W (8),
        .ADDR_W  (8)
    ) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .req_i     (req_i),
        .we_i      (we_i),
        .addr_i    (addr_i),
        .wdata_i   (wdata_i),
        .rdata_o   (rdata_o),
        .rvalid_o  (rvalid_o),
        .capture_i (capture_i),
        .irq_o     (irq_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            req_prev <= 1'b0;
            we_prev  <= 1'b0;
        end else begin
            req_prev <= req_i;
            we_prev  <= we_i;
        end
    end

    // Acknowledge timing every cycle; read data popped against the queue.
    always @(negedge clk_i) begin
        if (mon_en) begin
            checks++;
            assert (rvalid_o === req_prev) else begin
                failures++;
                $error("FAIL rvalid got=%b exp=%b", rvalid_o, req_prev);
            end
            if (req_prev && !we_prev) begin
                checks++;
                assert (sb_q.size() != 0) else begin
                    failures++;
                    $error("FAIL sb_underflow got=empty exp=entry");
                end
                if (sb_q.size() != 0) begin
                    item = sb_q.pop_front();
                    assert (rdata_o === item.exp) else begin
                        failures++;
                        $error("FAIL rd addr=%h got=%h exp=%h", item.addr, rdata_o, item.exp);
                    end
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic bus(input logic we, input logic [7:0] addr, input logic [31:0] data);
        req_i   = 1'b1;
        we_i    = we;
        addr_i  = addr;
        wdata_i = data;
        @(posedge clk_i);
        #1;
        req_i = 1'b0;
        we_i  = 1'b0;
    endtask

    task automatic wr(input logic [7:0] addr, input logic [31:0] data);
        bus(1'b1, addr, data);
    endtask

    task automatic rd(input logic [7:0] addr, input logic [31:0] exp);
        sb_q.push_back({addr, exp});
        bus(1'b0, addr, 32'h0);
    endtask

    initial begin
        logic [7:0] offs [5];
        offs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10};

        idle(3);
        chk("rst_irq", 32'(irq_o), 32'h0);
        chk("rst_rvalid", 32'(rvalid_o), 32'h0);
        chk("rst_rdata", rdata_o, 32'h0);
        rst_i = 1'b0;
        idle(1);
        mon_en = 1'b1;

        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 5; r++)
                rd(8'(c * 32) + offs[r], 32'h0);
        rd(8'h14, 32'h0);
        rd(8'h1C, 32'h0);
        rd(8'h80, 32'h0);

        // Channel 0: CMP=0x15, PRESC=0, EN+IRQ_EN; enable edge is E0
        wr(8'h04, 32'h15);
        wr(8'h00, 32'h5);
        idle(4);
        rd(8'h08, 32'h4);
        idle(16);
        chk("ch0_irq_before", 32'(irq_o[0]), 32'h0);
        idle(1);
        chk("ch0_irq_at22", 32'(irq_o[0]), 32'h1);
        rd(8'h0C, 32'h1);
        wr(8'h0C, 32'h1);
        chk("ch0_irq_w1c", 32'(irq_o[0]), 32'h0);
        idle(19);
        chk("ch0_irq_before2", 32'(irq_o[0]), 32'h0);
        idle(1);
        chk("ch0_irq_again", 32'(irq_o[0]), 32'h1);

        // Channel 1: PRESC=3, CMP=2, one-shot, IRQ_EN (E46 enable)
        wr(8'h24, 32'h2);
        wr(8'h20, 32'h307);
        idle(11);
        rd(8'h2C, 32'h0);
        chk("ch1_irq_at12", 32'(irq_o[1]), 32'h1);
        rd(8'h20, 32'h306);
        rd(8'h28, 32'h0);
        idle(8);
        rd(8'h28, 32'h0);
        rd(8'h08, 32'h3);

        // Channel 2: wrap without PEND, then match 0x21 ticks after COUNT write
        wr(8'h44, 32'h10);
        wr(8'h40, 32'h5);
        wr(8'h48, 32'hF0);
        rd(8'h48, 32'hF0);
        idle(16);
        rd(8'h4C, 32'h0);
        chk("ch2_irq_after_wrap", 32'(irq_o[2]), 32'h0);
        idle(14);
        chk("ch2_irq_before", 32'(irq_o[2]), 32'h0);
        idle(1);
        chk("ch2_irq_match", 32'(irq_o[2]), 32'h1);
        wr(8'h4C, 32'h1);
        chk("ch2_irq_w1c", 32'(irq_o[2]), 32'h0);
        idle(15);
        wr(8'h4C, 32'h1);
        rd(8'h4C, 32'h1);
        chk("ch2_irq_set_beats_w1c", 32'(irq_o[2]), 32'h1);

        // Channel 3: CMP=0 one-shot; CTRL write coincides with auto-clear
        wr(8'h60, 32'h3);
        wr(8'h60, 32'h7);
        rd(8'h60, 32'h7);
        rd(8'h60, 32'h6);
        rd(8'h68, 32'h0);
        chk("ch3_irq_cmp0", 32'(irq_o[3]), 32'h1);

        // Capture on channel 2 while COUNT=0x40
        wr(8'h44, 32'hFF);
        wr(8'h4C, 32'h3);
        wr(8'h48, 32'h40);
        capture_i[2] = 1'b1;
        idle(3);
        rd(8'h50, c_capt ? 32'h42 : 32'h0);
        rd(8'h4C, c_capt ? 32'h2 : 32'h0);
        chk("ch2_irq_capt", 32'(irq_o[2]), c_capt ? 32'h1 : 32'h0);
        wr(8'h4C, 32'h2);
        chk("ch2_irq_capt_w1c", 32'(irq_o[2]), 32'h0);

        // Asynchronous reset in mid-cycle
        idle(2);
        #2;
        rst_i = 1'b1;
        #1;
        chk("async_rst_irq", 32'(irq_o), 32'h0);
        chk("async_rst_rvalid", 32'(rvalid_o), 32'h0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        idle(1);
        rd(8'h00, 32'h0);
        rd(8'h08, 32'h0);
        rd(8'h0C, 32'h0);
        rd(8'h4C, 32'h0);
        idle(2);
        chk("sb_drained", 32'(sb_q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/rvj1_timer_multi.md
Name: rvj1_timer_multi

Overview:
Parametrised multi-channel timer/compare peripheral for the rvj1 SoC. It is the successor to the single free-running timer_inst, which wraps at a fixed count. Each channel has:
- a CNT_W-bit up-counter
- a per-channel prescaler
- a software-written compare value
- periodic or one-shot mode
- a sticky pending flag driving an interrupt line

It sits on the SoC's simple req/we/addr data bus, next to the other rvj1 peripherals.

Parameters:
NUM_CH, 4, number of independent timer channels (1..8)
CNT_W, 32, counter/compare width in bits (8..32)
PRESC_W, 8, per-channel prescaler width in bits (1..16)
ADDR_W, 8, byte-address width of the register port (must hold NUM_CH*0x20)

Ports:
clk_i  in  1  system clock (the only clock)
rst_i  in  1  asynchronous, active-high reset
req_i  in  1  bus request, one-cycle strobe
we_i  in  1  1=write, 0=read
addr_i  in  ADDR_W  byte address; bits [1:0] ignored
wdata_i  in  32  write data
rdata_o  out  32  read data, valid while rvalid_o=1
rvalid_o  out  1  read/write acknowledge, one cycle after req_i
capture_i  in  NUM_CH  async capture inputs; used only with TIMER_CAPTURE_EN
irq_o  out  NUM_CH  per-channel level interrupt

Behaviour:
- Reset is asynchronous and active-high.
- All registers reset to 0: rdata_o=0, rvalid_o=0, irq_o=0.
- Register map: channel n base = n*0x20.
  - +0x0 CTRL: bit0 EN, bit1 ONESHOT, bit2 IRQ_EN, bits[8+PRESC_W-1:8] PRESC.
  - +0x4 CMP.
  - +0x8 COUNT: read/write.
  - +0xC STATUS: bit0 PEND, bit1 CAPT_PEND; write-1-to-clear.
  - +0x10 CAPT: read-only.
- Unmapped or out-of-range addresses: reads return 0, writes are ignored.
- Bus: every req_i gets rvalid_o=1 exactly one cycle later.
  - Read data is registered and sampled at the req_i edge.
  - Writes take effect at the req_i edge.
  - Back-to-back requests every cycle are supported.
- Widths: writes are truncated to the field width; reads are zero-extended to 32 bits.
- Prescaler:
  - Each channel has a PRESC_W-bit divider; a tick fires when divider==PRESC, then the divider returns to 0. PRESC=0 gives a tick every cycle.
  - The divider is held at 0 while EN=0.
  - Any write to CTRL clears the divider.
- Count, on a tick with EN=1:
  - If COUNT==CMP: COUNT<=0, PEND<=1; if ONESHOT=1, also EN<=0.
  - Otherwise COUNT<=COUNT+1, wrapping from 2^CNT_W-1 to 0 with no PEND.
- CMP=0: PEND is set on every tick and COUNT stays 0.
- COUNT written above CMP: the counter runs to the top, wraps, then matches CMP.
- Simultaneous events:
  - A software COUNT write beats a tick increment.
  - PEND set by hardware beats a W1C in the same cycle, so PEND stays 1.
  - A CTRL write beats the one-shot auto-clear of EN.
- irq_o[n] = PEND[n] & IRQ_EN[n], driven from flops with no combinational path from the bus.
- Reset mid-count returns the channel to idle immediately; no pending is retained.

Optional Feature:
TIMER_CAPTURE_EN
- Defined:
  - capture_i[n] is synchronised through 2 flops.
  - A rising edge (detected from the synchronised value) copies COUNT into CAPT and sets CAPT_PEND.
  - irq_o[n] also asserts on CAPT_PEND & IRQ_EN.
  - Capture-to-CAPT latency is 3 clk_i cycles from the capture_i edge.
  - If a capture and a COUNT write coincide, CAPT receives the pre-write COUNT.
- Undefined: capture_i is ignored (no flops), CAPT reads 0, and CAPT_PEND reads 0.

Decomposition:
- Shared package rvj1_timer_pkg holds:
  - register offsets (CTRL/CMP/COUNT/STATUS/CAPT)
  - CTRL/STATUS bit-index constants
  - channel stride 0x20
- One sub-module, rvj1_timer_chan: a single channel's prescaler, counter, compare, mode and flags.
  - It receives decoded per-register write strobes and exposes its register values.
  - The top module does address decode, the read mux and the rvalid flop, and generates NUM_CH instances.

Test Plan:
- Reset then read each channel: all registers read 0, irq_o=0, and rvalid_o pulses exactly 1 cycle after each req_i.
- Ch0, CMP=0x15, PRESC=0, CTRL=0x5: COUNT cycles 0..0x15. PEND and irq_o[0] rise 22 cycles after enable. Write STATUS=1: irq_o[0] drops, then re-asserts 22 cycles later.
- Ch1, PRESC=3, CMP=2, ONESHOT=1: PEND is set after 12 cycles, EN auto-clears and COUNT stays at 0. Ch0 runs unaffected.
- CNT_W=8, COUNT=0xF0, CMP=0x10: no PEND at the 0xFF->0 wrap; PEND is set 0x21 ticks after the write.
- Drive a W1C of STATUS in the same cycle PEND is set: PEND reads 1 afterwards. A COUNT write coinciding with a tick: COUNT holds the written value.
- TIMER_CAPTURE_EN defined: rising edge on capture_i[2] while COUNT=0x40 gives CAPT=0x42 (3-cycle sync latency), CAPT_PEND=1 and irq_o[2]=1. Undefined: CAPT reads 0.
